tft_spi_sequencer: RTL and testbench

// - Word-level controller for the 16-bit TFT SPI shifter; runs in the SPI_CLK domain.
// - Sequences panel hard reset, then the init table from a sub-ROM.
// - On request, sends one frame: address window commands, then WIDTH*HEIGHT pixels from an upstream pixel FIFO.
// - Drives word/dc/cs; the shifter consumes one word per word_tick (every 16 SPI_CLK).

---
 rtl/tft_pkg.sv | 60 ++++++
 rtl/tft_init_rom.sv | 23 ++
 rtl/tft_spi_sequencer.sv | 175 +++++++++++++++++
 tb/tb_tft_spi_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared types and constants for the TFT SPI word sequencer.
package tft_pkg;

    // Init ROM entry type codes
    typedef enum logic [1:0] {
        ET_CMD = 2'd0,
        ET_DAT = 2'd1,
        ET_DLY = 2'd2,
        ET_END = 2'd3
    } entry_type_e;

    localparam int unsigned ROM_W     = 18;
    localparam int unsigned WIN_WORDS = 7;

    typedef struct packed {
        entry_type_e kind;
        logic [15:0] payload;
    } rom_entry_t;

    // One word as presented to the shifter
    typedef struct packed {
        logic        cs_n;
        logic        dc;
        logic [15:0] data;
    } spi_word_t;

    localparam logic [7:0] CASET = 8'h2A;
    localparam logic [7:0] RASET = 8'h2B;
    localparam logic [7:0] RAMWR = 8'h2C;

    localparam spi_word_t FILLER = '{cs_n: 1'b1, dc: 1'b1, data: 16'h0000};

    typedef enum logic [2:0] {
        S_RST_HOLD,
        S_RST_WAIT,
        S_INIT,
        S_DELAY,
        S_IDLE,
        S_WINDOW,
        S_STREAM
    } state_e;

    // Address-window command sequence: CASET 0..col_end, RASET 0..row_end, RAMWR
    function automatic spi_word_t window_word(input logic [2:0]  idx,
                                              input logic [15:0] col_end,
                                              input logic [15:0] row_end);
        spi_word_t w;
        w = '{cs_n: 1'b0, dc: 1'b1, data: 16'h0000};
        case (idx)
            3'd0:    begin w.dc = 1'b0; w.data = {CASET, 8'h00}; end
            3'd2:    w.data = col_end;
            3'd3:    begin w.dc = 1'b0; w.data = {RASET, 8'h00}; end
            3'd5:    w.data = row_end;
            3'd6:    begin w.dc = 1'b0; w.data = {RAMWR, 8'h00}; end
            default: w.data = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tft_init_rom.sv
// Panel init table, synchronous read with one cycle of latency.
module tft_init_rom
    import tft_pkg::*;
#(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output rom_entry_t    entry
);

    // Registered table lookup; unlisted entries terminate the table
    always_ff @(posedge clk) begin
        case (addr)
            AW'(0):  entry <= '{kind: ET_CMD, payload: 16'h0001};
            AW'(1):  entry <= '{kind: ET_DLY, payload: 16'd10};
            AW'(2):  entry <= '{kind: ET_DAT, payload: 16'h1234};
            default: entry <= '{kind: ET_END, payload: 16'h0000};
        endcase
    end

endmodule

// File: rtl/tft_spi_sequencer.sv
// Word-level TFT controller: hard reset, init table, then framed pixel streaming.
module tft_spi_sequencer
    import tft_pkg::*;
#(
    parameter int unsigned WIDTH      = 240,
    parameter int unsigned HEIGHT     = 320,
    parameter int unsigned RST_CYCLES = 2048,
    parameter int unsigned RST_WAIT   = 4096,
    parameter int unsigned ROM_DEPTH  = 64
) (
    input  logic        SPI_CLK,
    input  logic        reset,
    input  logic        word_tick,
    input  logic        frame_start,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [15:0] word_out,
    output logic        dc_out,
    output logic        cs_n,
    output logic        tft_rst_n,
    output logic        init_done,
    output logic        busy,
    output logic        underrun
);

    localparam int unsigned AW        = $clog2(ROM_DEPTH);
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned PIX_TOTAL = WIDTH * HEIGHT;
    localparam int unsigned PIX_W     = $clog2(PIX_TOTAL + 1);
    localparam logic [15:0] COL_END   = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_END   = 16'(HEIGHT - 1);

    state_e           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] delay_len_q, delay_len_nxt;
    logic [AW-1:0]    addr_q, addr_nxt;
    logic             addr_step;
    logic             rom_valid_q;
    logic [2:0]       win_idx_q, win_idx_nxt;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_nxt;
    spi_word_t        out_q, out_nxt;
    logic             init_done_nxt, underrun_nxt;
    rom_entry_t       rom_entry;

    tft_init_rom #(.DEPTH(ROM_DEPTH)) u_rom (
        .clk   (SPI_CLK),
        .addr  (addr_q),
        .entry (rom_entry)
    );

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign word_out  = out_q.data;
    assign dc_out    = out_q.dc;
    assign cs_n      = out_q.cs_n;
    assign pix_ready = !reset && word_tick && pix_valid && (state_q == S_STREAM);

    // State register
    always_ff @(posedge SPI_CLK) begin
        if (reset) state_q <= S_RST_HOLD;
        else       state_q <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_RST_HOLD: if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_nxt = S_RST_WAIT;
            S_RST_WAIT: if (cnt_q == CNT_W'(RST_WAIT - 1))   state_nxt = S_INIT;
            S_INIT: begin
                if (rom_valid_q) begin
                    if (rom_entry.kind == ET_DLY && rom_entry.payload != 16'd0) state_nxt = S_DELAY;
                    if (rom_entry.kind == ET_END)                               state_nxt = S_IDLE;
                end
            end
            S_DELAY:  if (cnt_inc == delay_len_q) state_nxt = S_INIT;
            S_IDLE:   if (frame_start) state_nxt = S_WINDOW;
            S_WINDOW: if (word_tick && win_idx_q == 3'(WIN_WORDS - 1)) state_nxt = S_STREAM;
            S_STREAM: if (word_tick && pix_valid && pix_cnt_q == PIX_W'(PIX_TOTAL - 1)) state_nxt = S_IDLE;
            default:  state_nxt = S_RST_HOLD;
        endcase
    end

    // Next values for counters, ROM address, flags and the word mux
    always_comb begin
        cnt_nxt       = cnt_q;
        delay_len_nxt = delay_len_q;
        addr_step     = 1'b0;
        win_idx_nxt   = win_idx_q;
        pix_cnt_nxt   = pix_cnt_q;
        out_nxt       = out_q;
        init_done_nxt = init_done;
        underrun_nxt  = underrun;
        if (word_tick) out_nxt = FILLER;
        case (state_q)
            S_RST_HOLD, S_RST_WAIT: cnt_nxt = (state_nxt != state_q) ? '0 : cnt_inc;
            S_INIT: begin
                if (rom_valid_q) begin
                    case (rom_entry.kind)
                        ET_CMD: if (word_tick) begin
                            out_nxt   = '{cs_n: 1'b0, dc: 1'b0, data: {rom_entry.payload[7:0], 8'h00}};
                            addr_step = 1'b1;
                        end
                        ET_DAT: if (word_tick) begin
                            out_nxt   = '{cs_n: 1'b0, dc: 1'b1, data: rom_entry.payload};
                            addr_step = 1'b1;
                        end
                        ET_DLY: begin
                            addr_step     = 1'b1;
                            cnt_nxt       = '0;
                            delay_len_nxt = rom_entry.payload;
                        end
                        default: init_done_nxt = 1'b1;
                    endcase
                end
            end
            S_DELAY: cnt_nxt = cnt_inc;
            S_IDLE: begin
                if (frame_start) begin
                    win_idx_nxt  = '0;
                    pix_cnt_nxt  = '0;
                    underrun_nxt = 1'b0;
                end
            end
            S_WINDOW: begin
                if (word_tick) begin
                    out_nxt     = window_word(win_idx_q, COL_END, ROW_END);
                    win_idx_nxt = win_idx_q + 3'd1;
                end
            end
            S_STREAM: begin
                if (word_tick) begin
                    if (pix_valid) begin
                        out_nxt     = '{cs_n: 1'b0, dc: 1'b1, data: pix_data};
                        pix_cnt_nxt = pix_cnt_q + PIX_W'(1);
                    end else begin
                        underrun_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        addr_nxt = addr_step ? addr_q + AW'(1) : addr_q;
    end

    // Datapath and registered outputs
    always_ff @(posedge SPI_CLK) begin
        if (reset) begin
            cnt_q       <= '0;
            delay_len_q <= '0;
            addr_q      <= '0;
            rom_valid_q <= 1'b0;
            win_idx_q   <= '0;
            pix_cnt_q   <= '0;
            out_q       <= FILLER;
            tft_rst_n   <= 1'b0;
            init_done   <= 1'b0;
            busy        <= 1'b1;
            underrun    <= 1'b0;
        end else begin
            cnt_q       <= cnt_nxt;
            delay_len_q <= delay_len_nxt;
            addr_q      <= addr_nxt;
            rom_valid_q <= !addr_step;
            win_idx_q   <= win_idx_nxt;
            pix_cnt_q   <= pix_cnt_nxt;
            out_q       <= out_nxt;
            tft_rst_n   <= (state_nxt != S_RST_HOLD);
            init_done   <= init_done_nxt;
            busy        <= (state_nxt != S_IDLE);
            underrun    <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_tft_spi_sequencer.sv
// Directed bench for tft_spi_sequencer on a 2x2 panel with short reset phases.
module tb_tft_spi_sequencer;

    localparam int unsigned WIDTH      = 2;
    localparam int unsigned HEIGHT     = 2;
    localparam int unsigned RST_CYCLES = 20;
    localparam int unsigned RST_WAIT   = 30;

    logic        SPI_CLK = 1'b0;
    logic        reset, word_tick, frame_start, pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic [15:0] word_out;
    logic        dc_out, cs_n, tft_rst_n, init_done, busy, underrun;

    int   errors = 0;
    int   checks = 0;
    int   ready_pulses = 0;
    logic tick_ready = 1'b0;

    logic [15:0] win_data [7] = '{16'h2A00, 16'h0000, 16'h0001, 16'h2B00, 16'h0000, 16'h0001, 16'h2C00};
    logic        win_dc   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] pix      [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};

    tft_spi_sequencer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .RST_CYCLES(RST_CYCLES), .RST_WAIT(RST_WAIT), .ROM_DEPTH(64)
    ) dut (
        .SPI_CLK(SPI_CLK), .reset(reset), .word_tick(word_tick), .frame_start(frame_start),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .word_out(word_out),
        .dc_out(dc_out), .cs_n(cs_n), .tft_rst_n(tft_rst_n), .init_done(init_done),
        .busy(busy), .underrun(underrun)
    );

    always #5 SPI_CLK = ~SPI_CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] d, input logic dc, input logic cs);
        chk({tag, "_data"}, 32'(word_out), 32'(d));
        chk({tag, "_dc"},   32'(dc_out),   32'(dc));
        chk({tag, "_cs_n"}, 32'(cs_n),     32'(cs));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge SPI_CLK);
        #1;
    endtask

    // Pulse word_tick for one cycle after a short gap; records pix_ready mid-cycle
    task automatic send_tick();
        repeat (2) @(posedge SPI_CLK);
        #1 word_tick = 1'b1;
        #2 tick_ready = pix_ready;
        if (pix_ready) ready_pulses++;
        @(posedge SPI_CLK);
        #1 word_tick = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge SPI_CLK);
        #1 frame_start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_word"},      32'(word_out),  32'h0);
        chk({tag, "_dc"},        32'(dc_out),    32'h1);
        chk({tag, "_cs_n"},      32'(cs_n),      32'h1);
        chk({tag, "_tft_rst_n"}, 32'(tft_rst_n), 32'h0);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 32'h0);
        chk({tag, "_init_done"}, 32'(init_done), 32'h0);
        chk({tag, "_busy"},      32'(busy),      32'h1);
        chk({tag, "_underrun"},  32'(underrun),  32'h0);
    endtask

    task automatic check_rst_low(input string tag);
        int n = 0;
        while (tft_rst_n === 1'b0 && n < 1000) begin
            n++;
            cycles(1);
        end
        chk(tag, 32'(n), 32'(RST_CYCLES));
    endtask

    // Seven window ticks, optionally pausing word_tick after a given word
    task automatic run_window(input string tag, input int hold_after);
        for (int i = 0; i < 7; i++) begin
            send_tick();
            chk_word($sformatf("%s_win%0d", tag, i), win_data[i], win_dc[i], 1'b0);
            if (i == hold_after) begin
                cycles(100);
                chk_word($sformatf("%s_hold", tag), win_data[i], win_dc[i], 1'b0);
            end
        end
    endtask

    initial begin
        int found, fillers, others, sent;
        logic v;
        reset = 1'b1; word_tick = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 16'h0;
        cycles(3);
        check_reset_values("reset");

        reset = 1'b0;
        check_rst_low("rst_hold_len");
        pulse_frame_start();
        chk("busy_rst_wait", 32'(busy), 32'h1);
        cycles(32);

        // Init table: CMD 01, delay, DAT 1234, END
        send_tick();
        chk_word("init_cmd", 16'h0100, 1'b0, 1'b0);
        pulse_frame_start();
        found = 0; fillers = 0; others = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            send_tick();
            if (word_out === 16'h1234 && dc_out === 1'b1 && cs_n === 1'b0) found = 1;
            else if (word_out === 16'h0 && dc_out === 1'b1 && cs_n === 1'b1) fillers++;
            else others++;
        end
        chk("init_dat_found", 32'(found), 32'h1);
        chk("init_fillers", 32'(fillers >= 1), 32'h1);
        chk("init_other_words", 32'(others), 32'h0);
        cycles(4);
        chk("init_done", 32'(init_done), 32'h1);
        chk("idle_busy", 32'(busy), 32'h0);
        send_tick();
        chk_word("idle_filler", 16'h0, 1'b1, 1'b1);
        chk("idle_busy2", 32'(busy), 32'h0);

        // Frame 1: all pixels valid, word_tick paused mid-window
        pulse_frame_start();
        chk("f1_busy", 32'(busy), 32'h1);
        ready_pulses = 0;
        run_window("f1", 2);
        chk("f1_win_no_ready", 32'(ready_pulses), 32'h0);
        pix_valid = 1'b1;
        for (int p = 0; p < 4; p++) begin
            pix_data = pix[p];
            send_tick();
            chk_word($sformatf("f1_pix%0d", p), pix[p], 1'b1, 1'b0);
            chk($sformatf("f1_ready%0d", p), 32'(tick_ready), 32'h1);
            if (p == 2) chk("f1_busy_before_last", 32'(busy), 32'h1);
        end
        pix_valid = 1'b0;
        chk("f1_busy_end", 32'(busy), 32'h0);
        chk("f1_ready_pulses", 32'(ready_pulses), 32'h4);
        chk("f1_underrun", 32'(underrun), 32'h0);
        send_tick();
        chk_word("f1_after", 16'h0, 1'b1, 1'b1);

        // Frame 2: second pixel tick starved, frame_start during STREAM
        pulse_frame_start();
        ready_pulses = 0;
        run_window("f2", -1);
        sent = 0;
        for (int t = 0; t < 5; t++) begin
            v = (t != 1);
            pix_valid = v;
            pix_data  = v ? pix[sent] : 16'hDEAD;
            send_tick();
            if (v) begin
                chk_word($sformatf("f2_pix%0d", sent), pix[sent], 1'b1, 1'b0);
                sent++;
            end else begin
                chk_word("f2_underrun_filler", 16'h0, 1'b1, 1'b1);
                chk("f2_underrun_noready", 32'(tick_ready), 32'h0);
                chk("f2_underrun_flag", 32'(underrun), 32'h1);
                pulse_frame_start();
            end
            if (t == 3) chk("f2_busy_before_last", 32'(busy), 32'h1);
        end
        pix_valid = 1'b0;
        chk("f2_busy_end", 32'(busy), 32'h0);
        chk("f2_ready_pulses", 32'(ready_pulses), 32'h4);
        chk("f2_underrun_sticky", 32'(underrun), 32'h1);

        // Frame 3: underrun cleared by start, then reset mid-STREAM
        pulse_frame_start();
        chk("f3_underrun_cleared", 32'(underrun), 32'h0);
        run_window("f3", -1);
        pix_valid = 1'b0;
        send_tick();
        chk("f3_underrun", 32'(underrun), 32'h1);
        pix_valid = 1'b1;
        pix_data  = 16'h1357;
        send_tick();
        chk_word("f3_pix", 16'h1357, 1'b1, 1'b0);
        reset = 1'b1; word_tick = 1'b1;
        cycles(1);
        check_reset_values("midreset");
        word_tick = 1'b0; pix_valid = 1'b0;
        reset = 1'b0;
        check_rst_low("rst_hold_len2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
